prod_accumulator: RTL
=====================

Name: prod_accumulator

Overview:
- Sequential stage directly downstream of the 4x4 array multiplier (module main, o[7:0]).
- Consumes a stream of 8-bit products under valid/ready handshake and accumulates them into a wider sum.
- Emits one result per frame. A frame ends on in_last or after MAX_TERMS terms.
- Turns the combinational multiplier into a dot-product / MAC datapath.

Parameters:
- PROD_W, 8, product width; matches the multiplier output.
- ACC_W, 16, accumulator width; must be >= PROD_W.
- MAX_TERMS, 16, forced frame flush after this many accepted terms; must be >= 1.
- CNT_W, $clog2(MAX_TERMS+1), term counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  product valid
- in_ready  out  1  stage can accept a product
- in_prod  in  PROD_W  unsigned product from multiplier
- in_last  in  1  final term of the frame, qualified by in_valid
- out_valid  out  1  frame result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  ACC_W  accumulated sum, modulo 2^ACC_W
- out_count  out  CNT_W  number of terms in the frame
- out_ovf  out  1  sticky: a carry out of ACC_W occurred in this frame

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-high on rst.
- On reset:
  - state = ACCUM, acc = 0, cnt = 0, ovf = 0.
  - out_valid = 0, out_sum = 0, out_count = 0, out_ovf = 0.
  - in_ready = 1 from the first clk edge after rst deasserts.
- FSM has two states, ACCUM and HOLD.
- ACCUM:
  - in_ready = 1 and out_valid = 0.
  - An input is accepted when in_valid && in_ready. On accept:
    - {carry, acc} <= acc + zero_ext(in_prod).
    - cnt <= cnt + 1.
    - ovf <= ovf | carry.
  - If the accepted term has in_last = 1, or cnt+1 == MAX_TERMS:
    - out_sum <= new acc, out_count <= cnt+1, out_ovf <= new ovf.
    - out_valid <= 1 and go to HOLD.
  - Latency: the result is visible on the cycle after the final term is accepted.
- HOLD:
  - in_ready = 0. in_prod and in_last are ignored.
  - out_sum, out_count, out_ovf and out_valid are held stable until out_ready.
  - On out_valid && out_ready:
    - out_valid <= 0; acc, cnt and ovf <= 0.
    - Go to ACCUM; the next frame's first term can be accepted the following cycle.
  - Minimum frame period is terms + 1 cycles.
- Outputs are registered. in_ready is a decode of state only, with no combinational path from out_ready.
- Boundary conditions:
  - in_last together with cnt+1 == MAX_TERMS: a single flush.
  - A frame of one term with in_last = 1 is legal: out_count = 1.
  - A zero-term frame is impossible; no output is produced without an accepted term.
  - in_prod = 0 terms still count toward out_count.
  - Sum wrap is modulo 2^ACC_W. out_ovf stays set for the rest of the frame and clears only on result handshake or reset.
  - Reset asserted mid-frame or in HOLD discards the partial sum and any pending result with no output; behaviour returns to the reset values above.
  - in_valid is sampled only while in_ready = 1. Upstream may drop valid without a handshake; this stage imposes no protocol check.

Decomposition:
- Shared package prod_acc_pkg holds:
  - the typedef state_t {ACCUM, HOLD};
  - localparam defaults PROD_W_DEF = 8 and ACC_W_DEF = 16.
- No sub-module is needed. The accumulate adder is a single ACC_W+1 wide add inline.
- A top-level integration instantiates main and prod_accumulator side by side; that wrapper is out of scope for this block.

Test Plan:
1. Basic frame: products 9, 225, 15 (last on 15), out_ready = 1 → one cycle later out_valid = 1, out_sum = 249, out_count = 3, out_ovf = 0. in_ready = 0 for exactly one cycle.
2. Backpressure: after scenario 1, hold out_ready = 0 for 5 cycles with in_valid = 1 → in_ready stays 0, out_* stable all 5 cycles, no term lost. On release, the next frame's first term is accepted the cycle after the handshake.
3. Forced flush: MAX_TERMS = 4, four products of 10 with in_last = 0 → out_sum = 40, out_count = 4. The 5th product starts a new frame with acc = 0.
4. Overflow: ACC_W = 8, products 200, 100, last → out_sum = 44, out_ovf = 1. The next frame of 1, last → out_sum = 1, out_ovf = 0.
5. Reset mid-operation:
   - Accept 50 and 60, assert rst for 1 cycle → all outputs 0, no out_valid. Then frame 7, last → out_sum = 7, out_count = 1.
   - Repeat with rst asserted during HOLD → the pending result is dropped.
6. Random MAC cross-check: drive random 4-bit x,y through main into this block with random in_valid/out_ready gaps → every out_sum equals the reference sum of x*y mod 2^ACC_W per frame, and out_count matches.

Source files
------------

// File: rtl/prod_acc_pkg.sv
// Shared types and defaults for the product accumulator stage.
// Downstream of the 4x4 array multiplier; turns it into a MAC path.
package prod_acc_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int PROD_W_DEF    = 8;
  localparam int ACC_W_DEF     = 16;
  localparam int MAX_TERMS_DEF = 16;

endpackage

// File: rtl/prod_accumulator.sv
// Accumulates a stream of products into one registered result per frame.
// A frame closes on in_last or after MAX_TERMS accepted terms.
module prod_accumulator
  import prod_acc_pkg::*;
#(
  parameter int PROD_W    = PROD_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int MAX_TERMS = MAX_TERMS_DEF,
  localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   ocnt_q, ocnt_d;
  logic               oovf_q, oovf_d;
  logic               vld_q, vld_d;

  logic [ACC_W:0]     add_w;
  logic [ACC_W-1:0]   acc_nxt;
  logic               carry;
  logic [CNT_W-1:0]   cnt_inc;
  logic               ovf_nxt;
  logic               accept;
  logic               flush;

  // ready is a pure state decode, never a path from out_ready
  assign in_ready = (state_q == ACCUM);
  assign accept   = in_valid && in_ready;

  assign add_w   = {1'b0, acc_q}
                 + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
  assign acc_nxt = add_w[ACC_W-1:0];
  assign carry   = add_w[ACC_W];
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign ovf_nxt = ovf_q | carry;
  assign flush   = in_last || (cnt_inc == CNT_W'(MAX_TERMS));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sum_d   = sum_q;
    ocnt_d  = ocnt_q;
    oovf_d  = oovf_q;
    vld_d   = vld_q;
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d = acc_nxt;
          cnt_d = cnt_inc;
          ovf_d = ovf_nxt;
          if (flush) begin
            sum_d   = acc_nxt;
            ocnt_d  = cnt_inc;
            oovf_d  = ovf_nxt;
            vld_d   = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (vld_q && out_ready) begin
          vld_d   = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      ocnt_q  <= '0;
      oovf_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      ocnt_q  <= ocnt_d;
      oovf_q  <= oovf_d;
      vld_q   <= vld_d;
    end
  end

  assign out_valid = vld_q;
  assign out_sum   = sum_q;
  assign out_count = ocnt_q;
  assign out_ovf   = oovf_q;

endmodule
